// File: rtl/nr_mem_pkg.sv
// rtl/nr_mem_pkg.sv - shared types and default widths for the unified memory port arbiter
package nr_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rtl/mem_port_arbiter_rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
  import nr_mem_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output logic   gnt_valid,
  output grant_t grant
);

  always_comb begin
    gnt_valid = req_i | req_d;
    grant     = GNT_I;
    if (req_i && req_d) begin
      // on contention the side that did not win last time goes first
      grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (req_d) begin
      grant = GNT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and data ports
module mem_port_arbiter
  import nr_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter bit D_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_data_read,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_data_write,
  input  logic              d_write_enable,
  output logic [DATA_W-1:0] d_data_read,
  output logic              d_data_valid,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_data_write,
  output logic              m_write_enable,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_data_read
);

  localparam grant_t LAST_GRANT_RST = D_FIRST ? GNT_I : GNT_D;

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic              m_req_q, m_req_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [DATA_W-1:0] m_data_write_q, m_data_write_d;
  logic              m_we_q, m_we_d;
  logic              i_valid_q, i_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] i_rd_q, i_rd_d;
  logic [DATA_W-1:0] d_rd_q, d_rd_d;

  logic   gnt_valid;
  grant_t grant;

  // a side whose valid is pulsing cannot be re-granted on its still-high req
  rr_pick2 u_pick (
    .req_i      (i_req & ~i_valid_q),
    .req_d      (d_req & ~d_valid_q),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .grant      (grant)
  );

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    m_req_d        = m_req_q;
    m_address_d    = m_address_q;
    m_data_write_d = m_data_write_q;
    m_we_d         = m_we_q;
    i_valid_d      = 1'b0;
    d_valid_d      = 1'b0;
    i_rd_d         = i_rd_q;
    d_rd_d         = d_rd_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          m_req_d      = 1'b1;
          last_grant_d = grant;
          if (grant == GNT_D) begin
            m_address_d    = d_address;
            m_data_write_d = d_data_write;
            m_we_d         = d_write_enable;
            state_d        = BUSY_D;
          end else begin
            m_address_d    = i_address;
            m_data_write_d = '0;
            m_we_d         = 1'b0;
            state_d        = BUSY_I;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_req_q && m_ready) begin
          m_req_d = 1'b0;
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            i_valid_d = 1'b1;
            if (!m_we_q) i_rd_d = m_data_read;
          end else begin
            d_valid_d = 1'b1;
            if (!m_we_q) d_rd_d = m_data_read;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      last_grant_q   <= LAST_GRANT_RST;
      m_req_q        <= 1'b0;
      m_address_q    <= '0;
      m_data_write_q <= '0;
      m_we_q         <= 1'b0;
      i_valid_q      <= 1'b0;
      d_valid_q      <= 1'b0;
      i_rd_q         <= '0;
      d_rd_q         <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      m_req_q        <= m_req_d;
      m_address_q    <= m_address_d;
      m_data_write_q <= m_data_write_d;
      m_we_q         <= m_we_d;
      i_valid_q      <= i_valid_d;
      d_valid_q      <= d_valid_d;
      i_rd_q         <= i_rd_d;
      d_rd_q         <= d_rd_d;
    end
  end

  assign m_req          = m_req_q;
  assign m_address      = m_address_q;
  assign m_data_write   = m_data_write_q;
  assign m_write_enable = m_we_q;
  assign i_data_valid   = i_valid_q;
  assign d_data_valid   = d_valid_q;
  assign i_data_read    = i_rd_q;
  assign d_data_read    = d_rd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vectors, corner sequences and scoreboarded stress
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, d_req, d_write_enable;
  logic [31:0] i_address, d_address, d_data_write;
  logic [31:0] i_data_read, d_data_read;
  logic        i_data_valid, d_data_valid;
  logic        m_req, m_write_enable, m_ready;
  logic [31:0] m_address, m_data_write, m_data_read;

  logic        auto_mem, man_ready, rnd_ready;
  logic [31:0] man_rdata;
  logic [31:0] mem [0:63];
  logic [31:0] shadow [0:63];

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_i, exp_d;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_req          (i_req),
    .i_address      (i_address),
    .i_data_read    (i_data_read),
    .i_data_valid   (i_data_valid),
    .d_req          (d_req),
    .d_address      (d_address),
    .d_data_write   (d_data_write),
    .d_write_enable (d_write_enable),
    .d_data_read    (d_data_read),
    .d_data_valid   (d_data_valid),
    .m_req          (m_req),
    .m_address      (m_address),
    .m_data_write   (m_data_write),
    .m_write_enable (m_write_enable),
    .m_ready        (m_ready),
    .m_data_read    (m_data_read)
  );

  function automatic logic [31:0] init_word(input int k);
    return 32'hC0DE0000 + 32'(k);
  endfunction

  assign m_ready     = auto_mem ? rnd_ready : man_ready;
  assign m_data_read = auto_mem ? mem[m_address[7:2]] : man_rdata;

  always @(posedge clk) begin
    rnd_ready <= ($urandom_range(0, 3) != 0);
    if (!auto_mem) begin
      for (int k = 0; k < 64; k++) mem[k] <= init_word(k);
    end else if (m_req && m_ready && m_write_enable) begin
      mem[m_address[7:2]] <= m_data_write;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.is_d) begin
      d_req = 1'b1; d_address = v.addr; d_write_enable = v.we; d_data_write = v.wdata;
    end else begin
      i_req = 1'b1; i_address = v.addr;
    end
    man_rdata = v.rdata;
    man_ready = 1'b0;
    tick();
    chk1("grant_m_req", m_req, 1'b1);
    chk32("grant_m_address", m_address, v.addr);
    chk1("grant_m_we", m_write_enable, v.we);
    if (v.we) chk32("grant_m_wdata", m_data_write, v.wdata);
    for (int k = 0; k < v.waits; k++) begin
      chk1("wait_m_req", m_req, 1'b1);
      chk32("wait_m_address", m_address, v.addr);
      chk1("wait_no_valid", v.is_d ? d_data_valid : i_data_valid, 1'b0);
      tick();
    end
    chk1("last_wait_m_req", m_req, 1'b1);
    man_ready = 1'b1;
    tick();
    if (v.is_d) begin
      chk1("d_valid_pulse", d_data_valid, 1'b1);
      chk1("i_valid_quiet", i_data_valid, 1'b0);
      chk32("d_read_data", d_data_read, v.exp_rd);
      chk32("i_read_untouched", i_data_read, exp_i);
      exp_d = v.exp_rd;
      d_req = 1'b0;
    end else begin
      chk1("i_valid_pulse", i_data_valid, 1'b1);
      chk1("d_valid_quiet", d_data_valid, 1'b0);
      chk32("i_read_data", i_data_read, v.exp_rd);
      chk32("d_read_untouched", d_data_read, exp_d);
      exp_i = v.exp_rd;
      i_req = 1'b0;
    end
    man_ready = 1'b0;
    tick();
    chk1("valid_one_cycle", v.is_d ? d_data_valid : i_data_valid, 1'b0);
    chk32("read_held", v.is_d ? d_data_read : i_data_read, v.exp_rd);
    chk1("idle_m_req", m_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        i_busy, d_busy, d_we_cur;
    int          i_age, d_age, i_done, d_done, i_issued, d_issued, a;
    logic [31:0] i_exp_s, d_exp_s, d_last;

    reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; i_address = '0; d_address = '0;
    d_data_write = '0; d_write_enable = 1'b0; man_ready = 1'b0; man_rdata = '0; auto_mem = 1'b0;
    exp_i = '0; exp_d = '0;

    vecs[0] = '{1'b0, 32'h100, 1'b0, 32'h0,      32'hDEADBEEF, 0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 32'h44,  1'b0, 32'h0,      32'h0BADF00D, 1, 32'h0BADF00D};
    vecs[2] = '{1'b1, 32'h40,  1'b1, 32'h12345678, 32'hFFFFFFFF, 3, 32'h0BADF00D};
    vecs[3] = '{1'b0, 32'h104, 1'b0, 32'h0,      32'h13579BDF, 2, 32'h13579BDF};
    vecs[4] = '{1'b1, 32'h48,  1'b0, 32'h0,      32'hCAFEF00D, 0, 32'hCAFEF00D};

    // reset held with both requests pending, then D wins first
    i_req = 1'b1; d_req = 1'b1; i_address = 32'h200; d_address = 32'h300;
    repeat (3) begin
      tick();
      chk1("rst_m_req", m_req, 1'b0);
      chk32("rst_outputs", m_address | m_data_write | i_data_read | d_data_read |
            {28'd0, m_req, m_write_enable, i_data_valid, d_data_valid}, 32'h0);
    end
    reset_n = 1'b1;
    tick();
    chk1("first_grant_m_req", m_req, 1'b1);
    chk32("first_grant_is_d", m_address, 32'h300);
    man_ready = 1'b1; man_rdata = 32'hA5A50001;
    tick();
    chk1("first_d_valid", d_data_valid, 1'b1);
    chk32("first_d_data", d_data_read, 32'hA5A50001);
    chk1("first_i_quiet", i_data_valid, 1'b0);
    i_req = 1'b0; d_req = 1'b0; man_ready = 1'b0;
    exp_d = 32'hA5A50001;
    tick();
    chk1("post_first_idle", m_req, 1'b0);

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // continuous contention: last grant was D, so I then D alternating
    i_address = 32'h500; d_address = 32'h600; d_write_enable = 1'b0;
    man_rdata = 32'h11112222; man_ready = 1'b1; i_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k % 2 == 1) begin
        chk1("alt_m_req", m_req, 1'b1);
        chk32("alt_grant_addr", m_address, (k % 4 == 1) ? 32'h500 : 32'h600);
        chk1("alt_no_valid", i_data_valid | d_data_valid, 1'b0);
      end else begin
        chk1("alt_gap_m_req", m_req, 1'b0);
        chk1("alt_i_valid", i_data_valid, (k % 4 == 2));
        chk1("alt_d_valid", d_data_valid, (k % 4 == 0));
      end
      if (k == 8) begin
        i_req = 1'b0; d_req = 1'b0; man_ready = 1'b0;
      end
    end
    tick();
    chk1("alt_end_idle", m_req, 1'b0);

    // asynchronous reset in the middle of a D transaction
    d_req = 1'b1; d_address = 32'h700; man_ready = 1'b0; man_rdata = 32'h77778888;
    tick();
    chk1("busy_d_m_req", m_req, 1'b1);
    chk32("busy_d_addr", m_address, 32'h700);
    i_req = 1'b1; i_address = 32'h800;
    #3 reset_n = 1'b0;
    #1;
    chk1("async_m_req_drop", m_req, 1'b0);
    chk32("async_d_read_clr", d_data_read, 32'h0);
    repeat (2) begin
      tick();
      chk1("rst_hold_m_req", m_req, 1'b0);
      chk1("rst_no_d_valid", d_data_valid, 1'b0);
    end
    reset_n = 1'b1;
    tick();
    chk1("rearb_m_req", m_req, 1'b1);
    chk32("rearb_d_wins", m_address, 32'h700);
    man_ready = 1'b1;
    tick();
    chk1("rearb_d_valid", d_data_valid, 1'b1);
    chk32("rearb_d_data", d_data_read, 32'h77778888);
    i_req = 1'b0; d_req = 1'b0; man_ready = 1'b0;
    tick();
    chk1("rearb_idle", m_req, 1'b0);

    // random stress: I reads words 0..31 (never written), D loads/stores words 32..63
    for (int k = 0; k < 64; k++) shadow[k] = init_word(k);
    auto_mem = 1'b1;
    i_busy = 1'b0; d_busy = 1'b0; d_we_cur = 1'b0; i_age = 0; d_age = 0;
    i_done = 0; d_done = 0; i_issued = 0; d_issued = 0;
    i_exp_s = '0; d_exp_s = '0; d_last = 32'h77778888;
    for (int cyc = 0; cyc < 700; cyc++) begin
      tick();
      chk1("dual_valid", i_data_valid & d_data_valid, 1'b0);
      if (i_data_valid) begin
        if (!i_busy) chk1("i_spurious_valid", i_data_valid, 1'b0);
        else chk32("stress_i_data", i_data_read, i_exp_s);
        i_busy = 1'b0; i_req = 1'b0; i_done++;
      end
      if (d_data_valid) begin
        if (!d_busy) chk1("d_spurious_valid", d_data_valid, 1'b0);
        else if (d_we_cur) chk32("stress_store_keeps", d_data_read, d_last);
        else begin
          chk32("stress_d_data", d_data_read, d_exp_s);
          d_last = d_exp_s;
        end
        d_busy = 1'b0; d_req = 1'b0; d_done++;
      end
      if (i_busy && ++i_age > 40) begin
        chk1("i_timeout", i_busy, 1'b0);
        i_busy = 1'b0; i_req = 1'b0;
      end
      if (d_busy && ++d_age > 40) begin
        chk1("d_timeout", d_busy, 1'b0);
        d_busy = 1'b0; d_req = 1'b0;
      end
      if (cyc < 600 && !i_busy && $urandom_range(0, 2) == 0) begin
        a = $urandom_range(0, 31);
        i_address = 32'(a) << 2; i_exp_s = init_word(a);
        i_req = 1'b1; i_busy = 1'b1; i_age = 0; i_issued++;
      end
      if (cyc < 600 && !d_busy && $urandom_range(0, 2) == 0) begin
        a = $urandom_range(32, 63);
        d_address = 32'(a) << 2;
        d_we_cur = 1'($urandom_range(0, 1));
        d_write_enable = d_we_cur;
        if (d_we_cur) begin
          d_data_write = $urandom;
          shadow[a] = d_data_write;
        end else begin
          d_exp_s = shadow[a];
        end
        d_req = 1'b1; d_busy = 1'b1; d_age = 0; d_issued++;
      end
    end
    chk32("stress_i_all_done", 32'(i_done), 32'(i_issued));
    chk32("stress_d_all_done", 32'(d_done), 32'(d_issued));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
